// File: rtl/mem_port_sequencer_pkg.sv
// Shared types for the unified memory port sequencer: FSM states, owner IDs, beat helpers.
package mem_port_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    localparam int WORD_BEATS = 4;
    localparam int WAIT_W     = 3;

    // Transaction attributes latched at grant
    typedef struct packed {
        owner_e      owner;
        logic        we;
        logic        word;
        logic [31:0] wdata;
    } txn_t;

    // Big-endian byte for a beat: beat 0 of a word is [31:24]; a byte access uses [7:0]
    function automatic logic [7:0] beat_byte(input logic [31:0] data, input logic word,
                                             input logic [1:0] beat);
        logic [31:0] sh;
        sh = data >> {~beat, 3'b000};
        return word ? sh[7:0] : data[7:0];
    endfunction

endpackage

// File: rtl/mem_port_sequencer_if.sv
// Requester and RAM-side signals of the memory port sequencer.
interface mem_port_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [31:0]       if_rdata;
    logic              mem_req;
    logic              mem_we;
    logic              mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              busy;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_rdata,
        input  if_ready, if_rdata, mem_ready, mem_rdata, ram_addr, ram_we, ram_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_rdata,
        output if_ready, if_rdata, mem_ready, mem_rdata, ram_addr, ram_we, ram_wdata, busy
    );
endinterface

// File: rtl/mem_port_sequencer_beat_timer.sv
// Beat sequencing: each beat lasts WAIT_STATES+1 cycles; flags the last cycle and the final beat.
module mem_port_sequencer_beat_timer
    import mem_port_sequencer_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic       en_i,
    input  logic [2:0] n_beats_i,
    output logic [1:0] beat_o,
    output logic       last_o,
    output logic       done_o
);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        beat_q, beat_d;

    assign last_o = (wait_q == WAIT_W'(WAIT_STATES));
    assign done_o = last_o && ({1'b0, beat_q} == n_beats_i - 3'd1);
    assign beat_o = beat_q;

    always_comb begin
        wait_d = wait_q;
        beat_d = beat_q;
        if (start_i) begin
            wait_d = '0;
            beat_d = '0;
        end else if (en_i) begin
            if (last_o) begin
                wait_d = '0;
                beat_d = beat_q + 2'd1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
            beat_q <= '0;
        end else begin
            wait_q <= wait_d;
            beat_q <= beat_d;
        end
    end
endmodule

// File: rtl/mem_port_sequencer.sv
// Arbitrates IF fetches and MEM loads/stores onto one byte-wide RAM port, in big-endian beats.
module mem_port_sequencer
    import mem_port_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_sequencer_if.slave bus
);
    state_e            state_q, state_d;
    txn_t              txn_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       sr_q, sr_shift;
    logic [31:0]       if_rdata_q, mem_rdata_q;
    logic              grant, in_beat, strobe;
    logic              last, done;
    logic [1:0]        beat;
    logic [2:0]        n_beats;

    mem_port_sequencer_beat_timer #(.WAIT_STATES(WAIT_STATES)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .start_i   (grant),
        .en_i      (in_beat),
        .n_beats_i (n_beats),
        .beat_o    (beat),
        .last_o    (last),
        .done_o    (done)
    );

    assign in_beat  = (state_q == BEAT);
    assign strobe   = in_beat && last;
    assign n_beats  = txn_q.word ? 3'(WORD_BEATS) : 3'd1;
    assign sr_shift = {sr_q[23:0], bus.ram_rdata};

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_req || bus.if_req) begin
                    grant   = 1'b1;
                    state_d = BEAT;
                end
            end
            BEAT:    if (done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            txn_q       <= '0;
            base_q      <= '0;
            sr_q        <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                // MEM has priority; IF is always a word read
                txn_q.owner <= bus.mem_req ? OWN_MEM : OWN_IF;
                txn_q.we    <= bus.mem_req && bus.mem_we;
                txn_q.word  <= !bus.mem_req || bus.mem_size;
                txn_q.wdata <= bus.mem_wdata;
                base_q      <= bus.mem_req ? bus.mem_addr : bus.if_addr;
                sr_q        <= '0;
            end else if (strobe && !txn_q.we) begin
                sr_q <= sr_shift;
                // Final byte goes straight into the owner's result as RESP is entered
                if (done) begin
                    if (txn_q.owner == OWN_IF) if_rdata_q  <= sr_shift;
                    else                       mem_rdata_q <= sr_shift;
                end
            end
        end
    end

    assign bus.ram_addr  = in_beat ? base_q + ADDR_W'(beat) : '0;
    assign bus.ram_we    = strobe && txn_q.we;
    assign bus.ram_wdata = (in_beat && txn_q.we) ? beat_byte(txn_q.wdata, txn_q.word, beat) : 8'h00;
    assign bus.if_ready  = (state_q == RESP) && (txn_q.owner == OWN_IF);
    assign bus.mem_ready = (state_q == RESP) && (txn_q.owner == OWN_MEM);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
